// File: rtl/branch_pred_pkg.sv
// Shared defaults and return-stack operation decode for the branch predictor.
package branch_pred_pkg;

  localparam int BTB_ENTRIES_DEF  = 16;
  localparam int BTB_CTR_BITS_DEF = 2;
  localparam int RAS_DEPTH_DEF    = 4;

  typedef enum logic [1:0] {
    RAS_NOP  = 2'd0,
    RAS_PUSH = 2'd1,
    RAS_POP  = 2'd2,
    RAS_SWAP = 2'd3
  } ras_op_t;

  // A push+pop pair on a non-empty stack replaces the top; on an empty stack
  // it degenerates to a plain push. A pop on an empty stack does nothing.
  function automatic ras_op_t ras_decode(input logic push, input logic pop,
                                         input logic nonempty);
    ras_op_t op;
    op = RAS_NOP;
    if (push && pop && nonempty) op = RAS_SWAP;
    else if (push)               op = RAS_PUSH;
    else if (pop && nonempty)    op = RAS_POP;
    return op;
  endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by the fetch, decode and predictor blocks.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack; overflow silently overwrites the oldest entry.
module return_stack
  import cpu_types_pkg::*;
  import branch_pred_pkg::*;
#(
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        push,
  input  logic [31:0] push_addr,
  input  logic        pop,
  input  logic        flush,
  output logic [31:0] top,
  output logic        empty,
  output logic        full
);

  localparam int              PW       = $clog2(RAS_DEPTH);
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(RAS_DEPTH);
  localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

  logic [PW-1:0] ptr_q;
  logic [PW:0]   cnt_q;
  word_t         stk_q [RAS_DEPTH];
  logic [PW-1:0] top_idx;
  ras_op_t       op;

  assign top_idx = ptr_q - PTR_ONE;
  assign op      = ras_decode(push, pop, cnt_q != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        stk_q[i] <= '0;
      end
    end else if (flush) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      unique case (op)
        RAS_PUSH: begin
          stk_q[ptr_q] <= push_addr;
          ptr_q        <= ptr_q + PTR_ONE;
          if (cnt_q != FULL_CNT) cnt_q <= cnt_q + CNT_ONE;
        end
        RAS_POP: begin
          ptr_q <= top_idx;
          cnt_q <= cnt_q - CNT_ONE;
        end
        RAS_SWAP: stk_q[top_idx] <= push_addr;
        default: ;
      endcase
    end
  end

  assign top   = (cnt_q != '0) ? stk_q[top_idx] : '0;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters plus a return-address stack.
module branch_predictor
  import cpu_types_pkg::*;
  import branch_pred_pkg::*;
#(
  parameter int ENTRIES   = BTB_ENTRIES_DEF,
  parameter int CTR_BITS  = BTB_CTR_BITS_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc,
  output logic        hit,
  output logic        taken,
  output logic [31:0] target,
  input  logic        WEN,
  input  logic [31:0] pc_w,
  input  logic [31:0] target_w,
  input  logic        taken_w,
  input  logic        ras_push,
  input  logic [31:0] ras_push_addr,
  input  logic        ras_pop,
  input  logic        flush,
  output logic [31:0] ras_top,
  output logic        ras_empty,
  output logic        ras_full
);

  localparam int                  IDX      = $clog2(ENTRIES);
  localparam int                  TAG_W    = 30 - IDX;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'((1 << CTR_BITS) - 1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
  localparam word_t               PC_STEP  = 32'd4;

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    word_t               target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
    return (c == CTR_MAX) ? c : c + CTR_ONE;
  endfunction

  function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
    return (c == '0) ? c : c - CTR_ONE;
  endfunction

  entry_t           btb_q [ENTRIES];

  logic [IDX-1:0]   idx_r;
  logic [TAG_W-1:0] tag_r;
  entry_t           rd_e;

  logic [IDX-1:0]   idx_w;
  logic [TAG_W-1:0] tag_w;
  entry_t           wr_e;
  logic             hit_w;

  // Byte offset bits never participate in indexing or tag compare.
  logic             unused_addr_bits;
  assign unused_addr_bits = ^{pc[1:0], pc_w[1:0]};

  // Lookup reads the registered table only, so a same-cycle update is not visible.
  assign idx_r  = pc[IDX+1:2];
  assign tag_r  = pc[31:IDX+2];
  assign rd_e   = btb_q[idx_r];
  assign hit    = rd_e.valid && (rd_e.tag == tag_r);
  assign taken  = hit && rd_e.ctr[CTR_BITS-1];
  assign target = taken ? rd_e.target : pc + PC_STEP;

  assign idx_w  = pc_w[IDX+1:2];
  assign tag_w  = pc_w[31:IDX+2];
  assign wr_e   = btb_q[idx_w];
  assign hit_w  = wr_e.valid && (wr_e.tag == tag_w);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '0;
      end
    end else if (WEN) begin
      if (hit_w) begin
        btb_q[idx_w].ctr <= taken_w ? sat_inc(wr_e.ctr) : sat_dec(wr_e.ctr);
        if (taken_w) btb_q[idx_w].target <= target_w;
      end else if (taken_w) begin
        btb_q[idx_w] <= '{valid: 1'b1, tag: tag_w, target: target_w, ctr: CTR_WEAK};
      end
    end
  end

  return_stack #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .RST       (RST),
    .push      (ras_push),
    .push_addr (ras_push_addr),
    .pop       (ras_pop),
    .flush     (flush),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, BTB entry count (power of two, at least 2); IDX = log2(ENTRIES).
REQ-002 SHALL have parameter CTR_BITS, default 2, saturating-counter width (1..4).
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-stack depth (power of two, at least 2).
REQ-004 SHALL have ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- RST  in  1  reset; synchronous, active-high.
- pc  in  32  fetch address.
- hit  out  1  BTB entry valid with matching tag.
- taken  out  1  predict taken.
- target  out  32  predicted next fetch address.
- WEN  in  1  branch-resolve update strobe.
- pc_w  in  32  resolved branch address.
- target_w  in  32  resolved branch target.
- taken_w  in  1  resolved outcome.
- ras_push  in  1  push return address (JAL).
- ras_push_addr  in  32  address to push.
- ras_pop  in  1  pop (JR $31).
- flush  in  1  clear return stack.
- ras_top  out  32  top of return stack.
- ras_empty  out  1  stack holds 0 entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.

Function
REQ-005 SHALL form index = addr[IDX+1:2] and tag = addr[31:IDX+2]; addr[1:0] SHALL be ignored.
REQ-006 SHALL produce hit, taken and target combinationally from pc in the same cycle, with zero latency.
REQ-007 SHALL drive hit = valid AND tag match; taken = hit AND counter MSB; target = stored target if taken, else pc+4 (mod 2^32).
REQ-008 On WEN with a hit at pc_w: SHALL increment the counter (saturating at 2^CTR_BITS-1) if taken_w, else decrement it (saturating at 0).
- SHALL overwrite the stored target with target_w only when taken_w.
REQ-009 On WEN with a miss (invalid entry or tag mismatch) and taken_w=1: SHALL allocate the entry, replacing any occupant.
- Allocation sets valid=1, the tag, target=target_w, and counter=2^(CTR_BITS-1) (weakly taken).
REQ-010 On WEN with a miss and taken_w=0: SHALL leave the table unchanged.
REQ-011 When a lookup and an update hit the same index in one cycle, the lookup SHALL return the pre-update contents (no bypass).
REQ-012 The return stack SHALL be a circular buffer with write pointer ptr (mod RAS_DEPTH) and occupancy count (0..RAS_DEPTH).
REQ-013 Push alone: SHALL write at ptr, then ptr+1 and count+1; count saturates at RAS_DEPTH, so overflow silently overwrites the oldest entry.
REQ-014 Pop alone with count>0: SHALL set ptr-1 and count-1; pop with count=0 SHALL be ignored.
REQ-015 Push and pop in the same cycle with count>0: SHALL overwrite the top entry with ras_push_addr, leaving ptr and count unchanged; with count=0 the pair SHALL behave as a push alone.
REQ-016 flush SHALL set ptr=0 and count=0, SHALL take priority over push/pop, and SHALL NOT affect the BTB table.
REQ-017 SHALL drive ras_top = entry[ptr-1] when count>0, else 0; ras_empty = (count==0); ras_full = (count==RAS_DEPTH).

Reset
REQ-018 RST SHALL take priority over WEN, push, pop and flush.
REQ-019 RST SHALL clear all valid bits, tags, targets, counters, ptr and count to 0.
REQ-020 In the cycle after reset, outputs SHALL be: hit=0, taken=0, target=pc+4, ras_top=0, ras_empty=1, ras_full=0.

Structure
REQ-021 SHALL reuse word_t from cpu_types_pkg.
REQ-022 Default parameter constants (BTB_ENTRIES_DEF, BTB_CTR_BITS_DEF, RAS_DEPTH_DEF) SHALL live in a shared package, branch_pred_pkg.
REQ-023 The entry struct SHALL be declared locally in the module, because its field widths depend on the parameters.
REQ-024 The return stack SHALL be a sub-module, return_stack, parametrised by RAS_DEPTH.

Verification (defaults)
REQ-025 After reset, pc=0x40 -> hit=0, taken=0, target=0x44.
REQ-026 Train and saturate:
- WEN, pc_w=0x40, target_w=0x80, taken_w=1; next cycle pc=0x40 -> hit=1, taken=1, target=0x80.
- Two not-taken updates -> taken=0, target=0x44, hit=1.
- A third not-taken update -> counter stays 0.
REQ-027 Aliasing: with 0x40 allocated, pc=0x80 (same index 0, different tag) -> hit=0.
- A taken update at 0x80 with target_w=0xC0 -> pc=0x40 misses, pc=0x80 gives target=0xC0.
REQ-028 Same-cycle conflict: with 0x40 valid and taken, present WEN (0x40, taken_w=0) and pc=0x40 together -> that cycle shows the old prediction.
REQ-029 Return-stack overflow and underflow:
- Push 0x100, 0x104, 0x108, 0x10C -> ras_full=1, ras_top=0x10C.
- Push 0x110 -> ras_top=0x110, ras_full=1.
- Four pops -> ras_top reads 0x10C, 0x108, 0x104, then ras_empty=1 with ras_top=0.
- A further pop -> no change.
REQ-030 Simultaneous events:
- Push 0x200 then push+pop with 0x300 -> ras_top=0x300, count=1.
- push+flush in one cycle -> ras_empty=1.
- RST asserted mid-train -> every output at its reset value in the next cycle.
